// File: rtl/note_oscillator.sv
`default_nettype none
// =============================================================================
// Module   : note_oscillator
// Purpose  : Single-voice DDS tone generator with click-free note changes,
//            emitting square / saw / triangle 8-bit samples at SAMPLE_DIV rate.
// Revision : 1.0  initial release
// =============================================================================
module note_oscillator #(
  parameter int SAMPLE_DIV = 1000,
  parameter int PHASE_W    = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] note_code,
  input  logic       note_valid,
  input  logic [1:0] wave_sel,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       playing
);

  localparam int               DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [DIV_W-1:0]   r_div;
  logic               w_tick;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nx;
  logic [PHASE_W-1:0] r_inc;
  logic [PHASE_W-1:0] w_inc_nx;
  logic [PHASE_W-1:0] w_sum;
  logic               w_carry;
  logic [PHASE_W-1:0] w_new_inc;
  logic [23:0]        w_inc7;
  logic               w_new_play;
  logic [7:0]         r_pend_code;
  logic [7:0]         w_pend_code_nx;
  logic               r_pend_flag;
  logic               w_pend_flag_nx;
  logic [7:0]         r_sample;
  logic [7:0]         w_sample_nx;
  logic               r_sample_valid;
  logic [8:0]         w_p;

  // Octave-7 increments: round(f * 2^24 / 40 kHz), C7 .. B7.
  always_comb begin
    w_inc7 = 24'd0;
    case (r_pend_code[3:0])
      4'd0:    w_inc7 = 24'd877870;
      4'd1:    w_inc7 = 24'd930071;
      4'd2:    w_inc7 = 24'd985375;
      4'd3:    w_inc7 = 24'd1043969;
      4'd4:    w_inc7 = 24'd1106047;
      4'd5:    w_inc7 = 24'd1171815;
      4'd6:    w_inc7 = 24'd1241495;
      4'd7:    w_inc7 = 24'd1315318;
      4'd8:    w_inc7 = 24'd1393531;
      4'd9:    w_inc7 = 24'd1476395;
      4'd10:   w_inc7 = 24'd1564186;
      4'd11:   w_inc7 = 24'd1657197;
      default: w_inc7 = 24'd0;
    endcase
  end

  assign w_new_inc  = PHASE_W'(w_inc7) >> (3'd7 - r_pend_code[6:4]);
  assign w_new_play = r_pend_code[7] && (r_pend_code[3:0] < 4'd12);
  assign w_tick     = (r_div == c_div_last);

  assign {w_carry, w_sum} = {1'b0, r_phase} + {1'b0, r_inc};
  assign w_p              = w_phase_nx[PHASE_W-1 -: 9];

  always_comb begin
    w_state_nx     = r_state;
    w_phase_nx     = r_phase;
    w_inc_nx       = r_inc;
    w_pend_code_nx = r_pend_code;
    w_pend_flag_nx = r_pend_flag;
    w_sample_nx    = r_sample;

    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          w_phase_nx = '0;
          if (r_pend_flag) begin
            w_pend_flag_nx = 1'b0;
            if (w_new_play) begin
              w_inc_nx   = w_new_inc;
              w_phase_nx = w_new_inc;
              w_state_nx = S_PLAY;
            end
          end
        end
        S_PLAY: begin
          w_phase_nx = w_sum;
          if (r_pend_flag) begin
            w_state_nx = S_CHANGE;
          end
        end
        S_CHANGE: begin
          w_phase_nx = w_sum;
          // Only swap notes on the period boundary so the waveform never jumps.
          if (w_carry) begin
            w_pend_flag_nx = 1'b0;
            if (w_new_play) begin
              w_inc_nx   = w_new_inc;
              w_state_nx = S_PLAY;
            end else begin
              w_phase_nx = '0;
              w_state_nx = S_IDLE;
            end
          end
        end
        default: begin
          w_phase_nx = '0;
          w_state_nx = S_IDLE;
        end
      endcase

      w_sample_nx = 8'h00;
      if (w_state_nx != S_IDLE) begin
        case (wave_sel)
          2'd0:    w_sample_nx = w_p[8] ? 8'hFF : 8'h00;
          2'd1:    w_sample_nx = w_p[8:1];
          2'd2:    w_sample_nx = w_p[8] ? ~w_p[7:0] : w_p[7:0];
          default: w_sample_nx = 8'h00;
        endcase
      end
    end

    // A strobe coincident with an apply becomes the next pending note.
    if (note_valid) begin
      w_pend_code_nx = note_code;
      w_pend_flag_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div          <= '0;
      r_state        <= S_IDLE;
      r_phase        <= '0;
      r_inc          <= '0;
      r_pend_code    <= 8'h00;
      r_pend_flag    <= 1'b0;
      r_sample       <= 8'h00;
      r_sample_valid <= 1'b0;
    end else begin
      r_div          <= w_tick ? '0 : r_div + 1'b1;
      r_state        <= w_state_nx;
      r_phase        <= w_phase_nx;
      r_inc          <= w_inc_nx;
      r_pend_code    <= w_pend_code_nx;
      r_pend_flag    <= w_pend_flag_nx;
      r_sample       <= w_sample_nx;
      r_sample_valid <= w_tick;
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign playing      = (r_state == S_PLAY) || (r_state == S_CHANGE);

endmodule
`default_nettype wire

// File: tb/tb_note_oscillator.sv
`default_nettype none
// =============================================================================
// Module   : tb_note_oscillator
// Purpose  : Self-checking bench for note_oscillator against a frequency-level
//            reference model; fast-tick instance plus a default-rate instance.
// Revision : 1.0  initial release
// =============================================================================
module tb_note_oscillator;

  localparam int FDIV = 10;
  localparam int SDIV = 1000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] note_code;
  logic       note_valid;
  logic [1:0] wave_sel;

  logic [7:0] f_sample;
  logic       f_valid;
  logic       f_playing;
  logic [7:0] s_sample;
  logic       s_valid;
  logic       s_playing;

  always #5 clk = ~clk;

  note_oscillator #(.SAMPLE_DIV(FDIV), .PHASE_W(24)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .note_code    (note_code),
    .note_valid   (note_valid),
    .wave_sel     (wave_sel),
    .sample       (f_sample),
    .sample_valid (f_valid),
    .playing      (f_playing)
  );

  note_oscillator dut_rate (
    .clk          (clk),
    .reset_n      (reset_n),
    .note_code    (note_code),
    .note_valid   (note_valid),
    .wave_sel     (wave_sel),
    .sample       (s_sample),
    .sample_valid (s_valid),
    .playing      (s_playing)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         slow_pulses = 0;
  bit         m_on, m_chg, m_pflag, m_tick;
  logic [7:0] m_pcode, m_sample;
  longint     m_phase, m_inc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_play(input logic [7:0] c);
    return c[7] && (c[3:0] < 4'd12);
  endfunction

  // Equal temperament anchored at A7 = 3520 Hz, 24-bit phase, 40 kHz sample rate.
  function automatic longint inc_of(input logic [7:0] c);
    real    f;
    real    x;
    longint i7;
    f  = 3520.0 * (2.0 ** ((real'(int'(c[3:0])) - 9.0) / 12.0));
    x  = f * 16777216.0 / 40000.0;
    i7 = longint'($floor(x + 0.5));
    return i7 >> (7 - int'(c[6:4]));
  endfunction

  function automatic logic [7:0] shape(input logic [1:0] w, input longint ph);
    int         p9;
    logic [7:0] r;
    p9 = int'(ph >> 15);
    case (w)
      2'd0:    r = (p9 >= 256) ? 8'hFF : 8'h00;
      2'd1:    r = 8'(p9 / 2);
      2'd2:    r = (p9 < 256) ? 8'(p9) : 8'(511 - p9);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    cyc = 0; m_on = 0; m_chg = 0; m_pflag = 0; m_tick = 0;
    m_pcode = 8'h00; m_sample = 8'h00; m_phase = 0; m_inc = 0;
  endtask

  task automatic model_tick();
    longint sum;
    if (!m_on) begin
      m_phase = 0;
      if (m_pflag) begin
        m_pflag = 0;
        if (is_play(m_pcode)) begin
          m_inc = inc_of(m_pcode); m_phase = m_inc; m_on = 1;
        end
      end
    end else begin
      sum = m_phase + m_inc;
      if (m_chg && sum >= 64'd16777216) begin
        m_pflag = 0; m_chg = 0;
        if (is_play(m_pcode)) begin
          m_inc = inc_of(m_pcode); m_phase = sum - 64'd16777216;
        end else begin
          m_on = 0; m_phase = 0;
        end
      end else begin
        m_phase = sum % 64'd16777216;
        if (m_pflag) m_chg = 1;
      end
    end
    m_sample = m_on ? shape(wave_sel, m_phase) : 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    m_tick = (cyc % FDIV) == 0;
    if (m_tick) model_tick();
    if (note_valid) begin m_pcode = note_code; m_pflag = 1; end
    #1;
    chk("fast_outputs", {22'd0, f_sample, f_valid, f_playing}, {22'd0, m_sample, m_tick, m_on});
    chk("rate_valid", {31'd0, s_valid}, {31'd0, (cyc % SDIV) == 0});
    if (s_valid) slow_pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_tick();
    for (int i = 0; i < FDIV; i++) begin
      step();
      if (m_tick) break;
    end
  endtask

  task automatic strobe(input logic [7:0] c);
    note_code = c; note_valid = 1'b1;
    step();
    note_valid = 1'b0;
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_fast"}, {22'd0, f_sample, f_valid, f_playing}, 32'd0);
    chk({tag, "_rate"}, {22'd0, s_sample, s_valid, s_playing}, 32'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 zero_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 zero_outputs("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] code;
    reset_n = 1'b0; note_code = 8'h00; note_valid = 1'b0; wave_sel = 2'd0;
    model_reset();
    #12 zero_outputs("reset_init");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: idle run at the real sample rate
    run(3500);
    chk("idle_rate_pulses", 32'(slow_pulses), 32'd3);
    chk("idle_rate_sample", {24'd0, s_sample}, 32'd0);
    chk("idle_rate_playing", {31'd0, s_playing}, 32'd0);

    // 2: A4 saw from idle
    mid_reset();
    wave_sel = 2'd1;
    strobe(8'hC9);
    wait_tick();
    chk("a4_saw_t1", {24'd0, f_sample}, 32'd2);
    chk("a4_playing", {31'd0, f_playing}, 32'd1);
    wait_tick();
    chk("a4_saw_t2", {24'd0, f_sample}, 32'd5);

    // 3: A7 square, first wrap on tick 12
    mid_reset();
    wave_sel = 2'd0;
    strobe(8'hF9);
    for (int k = 1; k <= 12; k++) begin
      wait_tick();
      chk($sformatf("a7_square_t%0d", k), {24'd0, f_sample},
          (k >= 6 && k <= 11) ? 32'hFF : 32'h00);
    end

    // 4: strobe landing on the apply edge, then last-wins before the wrap
    mid_reset();
    wave_sel = 2'd1;
    while ((cyc % FDIV) != FDIV - 2) step();
    strobe(8'hC9);
    strobe(8'hC0);
    run(200);
    strobe(8'hCB);
    run(1000);
    chk("b4_playing", {31'd0, f_playing}, 32'd1);

    // 5: stop codes wait for the wrap
    wave_sel = 2'd2;
    strobe(8'h00);
    run(1100);
    chk("stop_00_playing", {31'd0, f_playing}, 32'd0);
    chk("stop_00_sample", {24'd0, f_sample}, 32'd0);
    strobe(8'hC9);
    run(30);
    strobe(8'h8C);
    run(1100);
    chk("stop_8c_playing", {31'd0, f_playing}, 32'd0);

    // 6: reset mid-note, restart from phase 0
    strobe(8'hF9);
    run(40);
    mid_reset();
    wave_sel = 2'd2;
    strobe(8'hF9);
    wait_tick();
    chk("restart_tri", {24'd0, f_sample}, 32'd45);

    // Randomized notes, waves and strobe timing
    for (int i = 0; i < 25; i++) begin
      code[7]   = ($urandom_range(0, 7) != 0);
      code[6:4] = 3'($urandom_range(3, 7));
      code[3:0] = 4'($urandom_range(0, 13));
      wave_sel  = 2'($urandom_range(0, 3));
      strobe(code);
      if ($urandom_range(0, 3) == 0) begin
        code[3:0] = 4'($urandom_range(0, 11));
        strobe(code);
      end
      run(int'($urandom_range(5, 400)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
